regfile_writeback_arbiter: RTL

- Write-side master for the CPU's 32x32 register file.
- Merges two result sources onto the single register-file write port:
  - single-cycle ALU results;
  - multi-cycle multiply/divide (MDU) results, buffered in a small FIFO.
- Keeps a pending-register scoreboard so decode can stall on registers awaiting MDU writeback.
- rf_* outputs are registered on posedge clk; the register file captures them on the following negedge.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_result_fifo.sv | 74 +++++++
 rtl/regfile_writeback_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared widths and the writeback entry type used by the
//               register-file writeback arbiter and its MDU result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_fifo
// Description : Synchronous FIFO of wb_entry_t holding MDU results until the
//               register-file write port is free. Head is shown
//               combinationally (first-word fall-through).
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_push/i_entry - write strobe and entry
//               i_pop         - remove head entry
//               o_head        - current head entry (stale when empty)
//               o_count       - occupancy 0..DEPTH
//               o_full/o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  wb_entry_t                i_entry,
    input  logic                     i_pop,
    output wb_entry_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int                  c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]    c_DEPTH_CNT = DEPTH[c_PTR_W:0];

    wb_entry_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    // Storage has no reset: contents are only visible through the counted
    // window between the pointers.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_DEPTH_CNT);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_arbiter
// Description : Write-side master of the 32x32 register file. Merges ALU
//               results (priority) and buffered MDU results onto the single
//               write port, and tracks registers awaiting MDU writeback.
// Macro       : WB_MDU_BYPASS_EN - when defined, an MDU result arriving with
//               the FIFO empty and no ALU result goes straight to rf_*.
// Ports       : clk, reset             - clock, sync active-high reset
//               alu_valid/dest/data    - single-cycle ALU result
//               mdu_valid/ready/dest/data - MDU result handshake
//               issue_valid/issue_dest - mark register pending
//               query_src1/2, busy1/2  - decode pending lookup
//               rf_write/dest/data     - registered write port
//               fifo_count             - MDU buffer occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_dest,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          mdu_valid,
    output logic                          mdu_ready,
    input  logic [ADDR_W-1:0]             mdu_dest,
    input  logic [DATA_W-1:0]             mdu_data,
    input  logic                          issue_valid,
    input  logic [ADDR_W-1:0]             issue_dest,
    input  logic [ADDR_W-1:0]             query_src1,
    input  logic [ADDR_W-1:0]             query_src2,
    output logic                          busy1,
    output logic                          busy2,
    output logic                          rf_write,
    output logic [ADDR_W-1:0]             rf_dest,
    output logic [DATA_W-1:0]             rf_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // The FIFO entry type fixes DATA_W/ADDR_W to the package values; the
    // parameters exist for interface documentation and must match them.
    import wb_pkg::wb_entry_t;
    import wb_pkg::REG_ZERO;

    localparam int c_NREGS = 1 << ADDR_W;

    wb_entry_t             w_head;
    wb_entry_t             w_push_entry;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_bypass;
    logic                  w_sel_valid;
    logic [ADDR_W-1:0]     w_sel_dest;
    logic [DATA_W-1:0]     w_sel_data;
    logic                  w_clr;
    logic [c_NREGS-1:0]    w_pending_nxt;

    logic [c_NREGS-1:0]    r_pending;
    logic                  r_rf_write;
    logic [ADDR_W-1:0]     r_rf_dest;
    logic [DATA_W-1:0]     r_rf_data;

    // ------------------------------------------------------------------
    // MDU handshake and FIFO control
    // ------------------------------------------------------------------
    assign mdu_ready = !w_full;

`ifdef WB_MDU_BYPASS_EN
    assign w_bypass = !alu_valid && w_empty && mdu_valid && mdu_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push            = mdu_valid && mdu_ready && !w_bypass;
    assign w_pop             = !alu_valid && !w_empty;
    assign w_push_entry.dest = mdu_dest;
    assign w_push_entry.data = mdu_data;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ------------------------------------------------------------------
    // Write-port selection: ALU > FIFO head > (optional) MDU bypass
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_dest  = w_head.dest;
        w_sel_data  = w_head.data;
        w_clr       = 1'b0;
        if (alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_dest  = alu_dest;
            w_sel_data  = alu_data;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_clr       = 1'b1;
        end else if (w_bypass) begin
            w_sel_valid = 1'b1;
            w_sel_dest  = mdu_dest;
            w_sel_data  = mdu_data;
            w_clr       = 1'b1;
        end
    end

    // Writes to r0 are dropped at the port, but the FIFO still pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_write <= 1'b0;
            r_rf_dest  <= '0;
            r_rf_data  <= '0;
        end else if (w_sel_valid) begin
            r_rf_write <= (w_sel_dest != REG_ZERO);
            r_rf_dest  <= w_sel_dest;
            r_rf_data  <= w_sel_data;
        end else begin
            r_rf_write <= 1'b0;
        end
    end

    assign rf_write = r_rf_write;
    assign rf_dest  = r_rf_dest;
    assign rf_data  = r_rf_data;

    // ------------------------------------------------------------------
    // Pending scoreboard: set is applied after clear so it wins on a
    // same-index collision. ALU writes never clear.
    // ------------------------------------------------------------------
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_clr) begin
            w_pending_nxt[w_sel_dest] = 1'b0;
        end
        if (issue_valid && (issue_dest != REG_ZERO)) begin
            w_pending_nxt[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign busy1 = r_pending[query_src1];
    assign busy2 = r_pending[query_src2];

endmodule
`default_nettype wire
